// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-op decode at capture and EX-side operand forwarding.
// Latency ID->EX one cycle; stall holds all state, flush loads a bubble.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          ex_valid,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [2:0]    alu_op,
    output logic [RW-1:0] ex_dest,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_branch,
    output logic [DW-1:0] ex_store_data,
    output logic          load_use_stall
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOR = 3'd5
    } alu_op_t;

    typedef struct packed {
        logic          valid;
        alu_op_t       op;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          branch;
        logic          use_imm;
        logic [RW-1:0] dest;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
    } ex_t;

    ex_t     q;
    ex_t     d;
    logic    d_known;
    logic    d_writes;
    logic    d_zext;
    logic    d_dest_rd;
    logic    d_no_dest;

    always_comb begin
        d_known   = 1'b1;
        d_writes  = 1'b0;
        d_zext    = 1'b0;
        d_dest_rd = 1'b0;
        d_no_dest = 1'b0;
        d         = '0;
        unique case (id_opcode)
            OP_R: begin
                d_dest_rd = 1'b1;
                d_writes  = 1'b1;
                case (id_funct)
                    6'h20, 6'h21: d.op = ALU_ADD;
                    6'h22, 6'h23: d.op = ALU_SUB;
                    6'h24:        d.op = ALU_AND;
                    6'h25:        d.op = ALU_OR;
                    6'h27:        d.op = ALU_NOR;
                    6'h2A:        d.op = ALU_SLT;
                    default: begin
                        d.op     = ALU_ADD;
                        d_writes = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin d.op = ALU_ADD; d.use_imm = 1'b1; d_writes = 1'b1; end
            OP_SLTI: begin d.op = ALU_SLT; d.use_imm = 1'b1; d_writes = 1'b1; end
            OP_ANDI: begin d.op = ALU_AND; d.use_imm = 1'b1; d_writes = 1'b1; d_zext = 1'b1; end
            OP_ORI:  begin d.op = ALU_OR;  d.use_imm = 1'b1; d_writes = 1'b1; d_zext = 1'b1; end
            OP_LW:   begin d.op = ALU_ADD; d.use_imm = 1'b1; d_writes = 1'b1; d.memread = 1'b1; end
            OP_SW:   begin d.op = ALU_ADD; d.use_imm = 1'b1; d.memwrite = 1'b1; d_no_dest = 1'b1; end
            OP_BEQ:  begin d.op = ALU_SUB; d.branch = 1'b1; d_no_dest = 1'b1; end
            default: d_known = 1'b0;
        endcase
        d.valid    = 1'b1;
        d.dest     = d_no_dest ? '0 : (d_dest_rd ? id_rd : id_rt);
        d.regwrite = d_writes && (d.dest != '0);
        d.rs       = id_rs;
        d.rt       = id_rt;
        d.rs_data  = id_rs_data;
        d.rt_data  = id_rt_data;
        d.imm      = d_zext ? {{(DW-16){1'b0}}, id_imm} : {{(DW-16){id_imm[15]}}, id_imm};
    end

    // Invalid or undecodable instructions enter EX as an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= '0;
        end else if (!stall) begin
            if (id_valid && d_known) q <= d;
            else                     q <= '0;
        end
    end

    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] r, input logic [DW-1:0] rf);
        if (r != '0 && exmem_regwrite && exmem_rd == r)      return exmem_result;
        else if (r != '0 && memwb_regwrite && memwb_rd == r) return memwb_result;
        else                                                 return rf;
    endfunction

    logic id_uses_rt;

    assign ex_store_data = fwd(q.rt, q.rt_data);
    assign alu_in1       = fwd(q.rs, q.rs_data);
    assign alu_in2       = q.use_imm ? q.imm : ex_store_data;
    assign alu_op        = q.op;
    assign ex_valid      = q.valid;
    assign ex_dest       = q.dest;
    assign ex_regwrite   = q.regwrite;
    assign ex_memread    = q.memread;
    assign ex_memwrite   = q.memwrite;
    assign ex_branch     = q.branch;

    assign id_uses_rt     = (id_opcode == OP_R) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
    assign load_use_stall = q.valid && q.memread && (q.dest != '0) &&
                            ((q.dest == id_rs) || ((q.dest == id_rt) && id_uses_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal checks plus randomized traffic against an instruction-level model.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, load_use_stall;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [2:0]  alu_op;
    logic [4:0]  ex_dest;

    int total = 0;
    int bad = 0;
    bit check_en = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_store_data(ex_store_data),
        .load_use_stall(load_use_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model keeps the raw instruction sitting in EX and interprets it at check time.
    typedef struct packed {
        logic        valid;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
    } instr_t;

    instr_t m;

    function automatic bit known_op(input logic [5:0] o);
        return o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h0A || o == 6'h0C ||
               o == 6'h0D || o == 6'h23 || o == 6'h2B;
    endfunction

    always @(posedge clk) begin
        if (rst || flush) m <= '0;
        else if (!stall) begin
            m <= '{valid: id_valid && known_op(id_opcode), opc: id_opcode, fn: id_funct,
                   rs: id_rs, rt: id_rt, rd: id_rd, rsd: id_rs_data, rtd: id_rt_data, imm: id_imm};
        end
    end

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r != 0 && exmem_regwrite && exmem_rd == r) return exmem_result;
        if (r != 0 && memwb_regwrite && memwb_rd == r) return memwb_result;
        return rf;
    endfunction

    function automatic logic [2:0] mnemonic_op(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f == 6'h22 || f == 6'h23) return 3'd1;
            if (f == 6'h24) return 3'd2;
            if (f == 6'h25) return 3'd3;
            if (f == 6'h2A) return 3'd4;
            if (f == 6'h27) return 3'd5;
            return 3'd0;
        end
        if (o == 6'h0A) return 3'd4;
        if (o == 6'h0C) return 3'd2;
        if (o == 6'h0D) return 3'd3;
        if (o == 6'h04) return 3'd1;
        return 3'd0;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            logic [31:0] e_in1, e_in2, e_st, ext;
            logic [4:0]  e_dest;
            logic        e_rw, writes, is_r, imm_src, uses_rt, e_lus;
            logic [2:0]  e_op;
            e_in1 = 0; e_in2 = 0; e_st = 0; e_dest = 0; e_rw = 0; e_op = 0; e_lus = 0;
            if (m.valid) begin
                is_r    = (m.opc == 6'h00);
                writes  = is_r ? (m.fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A})
                               : (m.opc inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23});
                e_dest  = is_r ? m.rd : ((m.opc == 6'h2B || m.opc == 6'h04) ? 5'd0 : m.rt);
                e_rw    = writes && e_dest != 0;
                e_op    = mnemonic_op(m.opc, m.fn);
                ext     = (m.opc == 6'h0C || m.opc == 6'h0D) ? {16'h0, m.imm} : {{16{m.imm[15]}}, m.imm};
                imm_src = m.opc inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
                e_in1   = fwd(m.rs, m.rsd);
                e_st    = fwd(m.rt, m.rtd);
                e_in2   = imm_src ? ext : e_st;
                uses_rt = id_opcode == 6'h00 || id_opcode == 6'h2B || id_opcode == 6'h04;
                e_lus   = m.opc == 6'h23 && e_dest != 0 &&
                          (e_dest == id_rs || (e_dest == id_rt && uses_rt));
            end
            chk("m_valid", {31'b0, ex_valid}, {31'b0, m.valid});
            chk("m_in1", alu_in1, e_in1);
            chk("m_in2", alu_in2, e_in2);
            chk("m_store", ex_store_data, e_st);
            chk("m_op", {29'b0, alu_op}, {29'b0, e_op});
            chk("m_dest", {27'b0, ex_dest}, {27'b0, e_dest});
            chk("m_ctrl", {28'b0, ex_regwrite, ex_memread, ex_memwrite, ex_branch},
                {28'b0, e_rw, m.valid && m.opc == 6'h23, m.valid && m.opc == 6'h2B, m.valid && m.opc == 6'h04});
            chk("m_lus", {31'b0, load_use_stall}, {31'b0, e_lus});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_opcode = 6'h00; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = {rd, 5'd0, fn};
    endtask

    task automatic set_i(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_opcode = opc; id_funct = imm[5:0]; id_rs = rs; id_rt = rt; id_rd = imm[15:11];
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic no_fwd();
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    logic [5:0] ops[9];
    logic [5:0] fns[9];

    initial begin
        ops = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
        rst = 1; stall = 0; flush = 0;
        set_i(6'h00, 0, 0, 0, 0, 0); id_valid = 0;
        no_fwd();
        tick();
        check_en = 1;
        tick();
        // 1: reset state, then add $3,$1,$2
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ctrl", {27'b0, ex_regwrite, ex_memread, ex_memwrite, ex_branch, load_use_stall}, 32'd0);
        chk("rst_op", {29'b0, alu_op}, 32'd0);
        chk("rst_dest", {27'b0, ex_dest}, 32'd0);
        rst = 0;
        set_r(6'h20, 1, 2, 3, 5, 7);
        tick();
        chk("add_in1", alu_in1, 32'd5);
        chk("add_in2", alu_in2, 32'd7);
        chk("add_op", {29'b0, alu_op}, 32'd0);
        chk("add_dest", {27'b0, ex_dest}, 32'd3);
        // 2: immediate extension
        set_i(6'h08, 1, 4, 16'hFFFF, 10, 0);
        tick();
        chk("addi_in2", alu_in2, 32'hFFFF_FFFF);
        chk("addi_op", {29'b0, alu_op}, 32'd0);
        set_i(6'h0D, 1, 4, 16'hFFFF, 10, 0);
        tick();
        chk("ori_in2", alu_in2, 32'h0000_FFFF);
        chk("ori_op", {29'b0, alu_op}, 32'd3);
        // 3: forwarding priority
        set_r(6'h20, 2, 3, 6, 32'h99, 32'h1);
        exmem_regwrite = 1; exmem_rd = 2; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 2; memwb_result = 32'h22;
        tick();
        chk("fwd_exmem", alu_in1, 32'h11);
        exmem_regwrite = 0;
        #1;
        chk("fwd_memwb", alu_in1, 32'h22);
        set_r(6'h20, 0, 3, 6, 32'h33, 32'h1);
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        tick();
        chk("fwd_r0", alu_in1, 32'h33);
        no_fwd();
        // 4: load-use hazard
        set_i(6'h23, 1, 5, 16'h0004, 32'h100, 0);
        tick();
        set_r(6'h20, 5, 1, 6, 32'h7, 32'h8);
        #1;
        chk("lus_raise", {31'b0, load_use_stall}, 32'd1);
        stall = 1; flush = 1;
        tick();
        chk("lus_bubble", {31'b0, ex_valid}, 32'd0);
        chk("lus_clear", {31'b0, load_use_stall}, 32'd0);
        stall = 0; flush = 0;
        tick();
        chk("lus_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("lus_add_dest", {27'b0, ex_dest}, 32'd6);
        // 5: stall holds for three cycles
        set_i(6'h0D, 3, 7, 16'h00F0, 32'h100, 0);
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            set_i(ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom);
            tick();
            chk("hold_in1", alu_in1, 32'h100);
            chk("hold_in2", alu_in2, 32'hF0);
            chk("hold_dest", {27'b0, ex_dest}, 32'd7);
        end
        flush = 1;
        tick();
        chk("hold_flush", {31'b0, ex_valid}, 32'd0);
        flush = 0; stall = 0;
        // 6: non-writing cases and beq
        set_r(6'h3F, 1, 2, 4, 1, 2);
        tick();
        chk("badfn_rw", {30'b0, ex_valid, ex_regwrite}, 32'd2);
        set_r(6'h20, 1, 2, 0, 1, 2);
        tick();
        chk("rd0_rw", {31'b0, ex_regwrite}, 32'd0);
        set_i(6'h04, 1, 2, 16'h0003, 9, 9);
        tick();
        chk("beq_op", {29'b0, alu_op}, 32'd1);
        chk("beq_in2", alu_in2, 32'd9);
        chk("beq_br", {31'b0, ex_branch}, 32'd1);
        stall = 1; rst = 1;
        tick();
        chk("rst_in_stall", {30'b0, ex_valid, ex_branch}, 32'd0);
        stall = 0; rst = 0;
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_i(($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom), $urandom, $urandom);
            id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
            id_rd    = 5'($urandom_range(0, 7));
            id_valid = ($urandom_range(0, 7) != 0);
            exmem_regwrite = $urandom_range(0, 1) == 1; exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_regwrite = $urandom_range(0, 1) == 1; memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
            tick();
        end
        @(negedge clk);
        #1;
        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
